// File: rtl/md_bus_pkg.sv
// Shared constants for the board-level bus resolver: resolution modes and
// the width of the saturating contention counter.
package md_bus_pkg;

  localparam int BUS_MERGE     = 0;
  localparam int BUS_PULLUP    = 1;
  localparam int BUS_WIRED_AND = 2;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/md_bus_resolver_if.sv
// Driver-side and resolved-side signals of one shared bus. The master modport
// belongs to whoever supplies the drivers, the slave modport to the resolver.
interface md_bus_resolver_if
  import md_bus_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DRIVERS = 4
);

  logic [DRIVERS*WIDTH-1:0] drv_o;
  logic [DRIVERS*WIDTH-1:0] drv_d;
  logic                     cnt_clear;
  logic [WIDTH-1:0]         bus;
  logic                     floating;
  logic                     conflict;
  cnt_t                     conflict_cnt;

  modport master (
    output drv_o, drv_d, cnt_clear,
    input  bus, floating, conflict, conflict_cnt
  );

  modport slave (
    input  drv_o, drv_d, cnt_clear,
    output bus, floating, conflict, conflict_cnt
  );

endinterface

// File: rtl/md_bus_decay.sv
// Open-bus idle counter: counts fully undriven cycles, saturates at DECAY and
// strobes decay_now_o on the idle sample that brings the count to DECAY.
module md_bus_decay #(
  parameter int DECAY = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  output logic decay_now_o
);

  localparam int CW = (DECAY > 0) ? $clog2(DECAY + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (idle_i) begin
      if (int'(cnt_q) >= DECAY) cnt_d = cnt_q;
      else                      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Once saturated the strobe stays high, which keeps the bus at FLOAT_VAL.
  assign decay_now_o = (DECAY > 0) && idle_i && (int'(cnt_q) >= DECAY - 1);

endmodule

// File: rtl/md_bus_resolver.sv
// Registered N-driver resolver for one shared bus: MERGE/PULLUP/WIRED_AND
// resolution, bus keeper with open-bus decay, contention flag and counter.
module md_bus_resolver
  import md_bus_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DRIVERS   = 4,
  parameter int               MODE      = BUS_MERGE,
  parameter logic [WIDTH-1:0] RESET_VAL = '1,
  parameter int               DECAY     = 0,
  parameter logic [WIDTH-1:0] FLOAT_VAL = '0
) (
  input  logic                MCLK,
  input  logic                reset,
  md_bus_resolver_if.slave    bus_if
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
    $error("md_bus_resolver: WIDTH must be 1..32");
  end
  if (DRIVERS < 1 || DRIVERS > 8) begin : g_chk_drivers
    $error("md_bus_resolver: DRIVERS must be 1..8");
  end
  if (MODE < BUS_MERGE || MODE > BUS_WIRED_AND) begin : g_chk_mode
    $error("md_bus_resolver: MODE must be 0..2");
  end
  if (DECAY < 0) begin : g_chk_decay
    $error("md_bus_resolver: DECAY must be >= 0");
  end

  logic [WIDTH-1:0] bus_q, bus_d;
  logic [WIDTH-1:0] driven;
  logic [WIDTH-1:0] contend;
  logic             floating_q, conflict_q;
  cnt_t             cnt_q, cnt_d;
  logic             idle;
  logic             decay_now;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic drv_any, hi, lo;

    always_comb begin
      drv_any = 1'b0;
      hi      = 1'b0;
      lo      = 1'b0;
      for (int k = 0; k < DRIVERS; k++) begin
        if (!bus_if.drv_d[k*WIDTH + b]) begin
          drv_any = 1'b1;
          if (bus_if.drv_o[k*WIDTH + b]) hi = 1'b1;
          else                           lo = 1'b1;
        end
      end
    end

    assign driven[b] = drv_any;

    // Disagreement among driven drivers means both a 1 and a 0 were seen.
    if (MODE == BUS_WIRED_AND) begin : g_wand
      assign bus_d[b]   = ~lo;
      assign contend[b] = 1'b0;
    end else if (MODE == BUS_PULLUP) begin : g_pullup
      assign bus_d[b]   = drv_any ? hi : 1'b1;
      assign contend[b] = hi & lo;
    end else begin : g_merge
      assign bus_d[b]   = drv_any   ? hi           :
                          decay_now ? FLOAT_VAL[b] : bus_q[b];
      assign contend[b] = hi & lo;
    end
  end

  assign idle = ~|driven;

  md_bus_decay #(
    .DECAY ((MODE == BUS_MERGE) ? DECAY : 0)
  ) u_decay (
    .clk_i       (MCLK),
    .rst_i       (reset),
    .idle_i      (idle),
    .decay_now_o (decay_now)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (bus_if.cnt_clear)               cnt_d = '0;
    else if (conflict_q && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      bus_q      <= RESET_VAL;
      floating_q <= 1'b1;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bus_q      <= bus_d;
      floating_q <= idle;
      conflict_q <= |contend;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_if.bus          = bus_q;
  assign bus_if.floating     = floating_q;
  assign bus_if.conflict     = conflict_q;
  assign bus_if.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_md_bus_resolver.sv
// Bench for md_bus_resolver: four instances (MERGE, MERGE+decay, PULLUP,
// WIRED_AND) run against a bit-level reference model of the resolution rules.
module tb_md_bus_resolver;
  import md_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_bus_resolver_if #(.WIDTH(16), .DRIVERS(4)) if_m ();
  md_bus_resolver_if #(.WIDTH(16), .DRIVERS(4)) if_d ();
  md_bus_resolver_if #(.WIDTH(1),  .DRIVERS(4)) if_p ();
  md_bus_resolver_if #(.WIDTH(1),  .DRIVERS(3)) if_w ();

  md_bus_resolver #(.WIDTH(16), .DRIVERS(4), .MODE(BUS_MERGE), .RESET_VAL(16'hFFFF),
                    .DECAY(0), .FLOAT_VAL(16'h0000))
    u_m (.MCLK(clk), .reset(rst), .bus_if(if_m));
  md_bus_resolver #(.WIDTH(16), .DRIVERS(4), .MODE(BUS_MERGE), .RESET_VAL(16'hFFFF),
                    .DECAY(4), .FLOAT_VAL(16'h0000))
    u_d (.MCLK(clk), .reset(rst), .bus_if(if_d));
  md_bus_resolver #(.WIDTH(1), .DRIVERS(4), .MODE(BUS_PULLUP), .RESET_VAL(1'b1),
                    .DECAY(0), .FLOAT_VAL(1'b0))
    u_p (.MCLK(clk), .reset(rst), .bus_if(if_p));
  md_bus_resolver #(.WIDTH(1), .DRIVERS(3), .MODE(BUS_WIRED_AND), .RESET_VAL(1'b1),
                    .DECAY(0), .FLOAT_VAL(1'b0))
    u_w (.MCLK(clk), .reset(rst), .bus_if(if_w));

  localparam int P_MODE [4] = '{0, 0, 1, 2};
  localparam int P_W    [4] = '{16, 16, 1, 1};
  localparam int P_N    [4] = '{4, 4, 4, 3};
  localparam int P_DEC  [4] = '{0, 4, 0, 0};
  localparam logic [31:0] P_RV [4] = '{32'hFFFF, 32'hFFFF, 32'h1, 32'h1};

  int checks = 0;
  int errors = 0;

  logic [255:0] s_o [4];
  logic [255:0] s_d [4];
  logic         s_clr [4];

  logic [31:0] m_bus [4];
  logic        m_float [4];
  logic        m_conf [4];
  logic [15:0] m_cnt [4];
  int          m_idle [4];

  task automatic release_all();
    for (int i = 0; i < 4; i++) begin
      s_o[i] = '0; s_d[i] = '1; s_clr[i] = 1'b0;
    end
  endtask

  task automatic drive();
    if_m.drv_o = s_o[0][63:0]; if_m.drv_d = s_d[0][63:0]; if_m.cnt_clear = s_clr[0];
    if_d.drv_o = s_o[1][63:0]; if_d.drv_d = s_d[1][63:0]; if_d.cnt_clear = s_clr[1];
    if_p.drv_o = s_o[2][3:0];  if_p.drv_d = s_d[2][3:0];  if_p.cnt_clear = s_clr[2];
    if_w.drv_o = s_o[3][2:0];  if_w.drv_d = s_d[3][2:0];  if_w.cnt_clear = s_clr[3];
  endtask

  // Rules stated per bit: count driven ones and zeros, then apply the mode.
  function automatic void ref_resolve(input int i, output logic [31:0] nbus,
                                      output logic nfloat, output logic nconf,
                                      output int nidle);
    int  ones, zeros;
    logic any_drv;
    any_drv = 1'b0; nconf = 1'b0; nbus = m_bus[i];
    for (int b = 0; b < P_W[i]; b++) begin
      ones = 0; zeros = 0;
      for (int k = 0; k < P_N[i]; k++)
        if (s_d[i][k*P_W[i] + b] == 1'b0) begin
          if (s_o[i][k*P_W[i] + b]) ones++; else zeros++;
        end
      if (ones + zeros > 0) any_drv = 1'b1;
      if (P_MODE[i] == 2)           nbus[b] = (zeros == 0);
      else if (ones + zeros > 0)    nbus[b] = (ones > 0);
      else if (P_MODE[i] == 1)      nbus[b] = 1'b1;
      if (P_MODE[i] != 2 && ones > 0 && zeros > 0) nconf = 1'b1;
    end
    nfloat = !any_drv;
    nidle  = 0;
    if (P_MODE[i] == 0 && P_DEC[i] > 0 && !any_drv) begin
      nidle = (m_idle[i] >= P_DEC[i]) ? P_DEC[i] : m_idle[i] + 1;
      if (nidle == P_DEC[i]) nbus = 32'h0;
    end
  endfunction

  task automatic model_step();
    logic [31:0] nb; logic nf, nc; int ni;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_bus[i] = P_RV[i]; m_float[i] = 1'b1; m_conf[i] = 1'b0;
        m_cnt[i] = 16'h0;   m_idle[i] = 0;
      end else begin
        if (s_clr[i])                              m_cnt[i] = 16'h0;
        else if (m_conf[i] && m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'h1;
        ref_resolve(i, nb, nf, nc, ni);
        m_bus[i] = nb; m_float[i] = nf; m_conf[i] = nc; m_idle[i] = ni;
      end
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] rd_bus(input int i);
    case (i)
      0:       return {16'h0, if_m.bus};
      1:       return {16'h0, if_d.bus};
      2:       return {31'h0, if_p.bus};
      default: return {31'h0, if_w.bus};
    endcase
  endfunction

  function automatic logic [17:0] rd_flags(input int i);
    case (i)
      0:       return {if_m.floating, if_m.conflict, if_m.conflict_cnt};
      1:       return {if_d.floating, if_d.conflict, if_d.conflict_cnt};
      2:       return {if_p.floating, if_p.conflict, if_p.conflict_cnt};
      default: return {if_w.floating, if_w.conflict, if_w.conflict_cnt};
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; release_all();
    step(); step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_bus(i) !== P_RV[i]) begin
        errors++; $display("FAIL reset_bus[%0d]: got %h expected %h", i, rd_bus(i), P_RV[i]);
      end
      checks++;
      if (rd_flags(i) !== {1'b1, 1'b0, 16'h0}) begin
        errors++; $display("FAIL reset_flags[%0d]: got %h expected %h", i, rd_flags(i), {1'b1, 1'b0, 16'h0});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_merge();
    release_all();
    s_o[0][15:0] = 16'h1234; s_d[0][15:0] = 16'h0000;
    step();
    checks++;
    if (if_m.bus !== 16'h1234 || if_m.floating !== 1'b0) begin
      errors++; $display("FAIL merge_drive: got bus=%h fl=%b expected bus=1234 fl=0", if_m.bus, if_m.floating);
    end
    release_all();
    step();
    checks++;
    if (if_m.bus !== 16'h1234 || if_m.floating !== 1'b1) begin
      errors++; $display("FAIL merge_keep: got bus=%h fl=%b expected bus=1234 fl=1", if_m.bus, if_m.floating);
    end
  endtask

  task automatic test_contention();
    release_all();
    s_o[0][15:0]  = 16'h00F0; s_d[0][15:0]  = 16'h0000;
    s_o[0][47:32] = 16'h000F; s_d[0][47:32] = 16'h0000;
    step();
    checks++;
    if (if_m.bus !== 16'h00FF || if_m.conflict !== 1'b1 || if_m.conflict_cnt !== 16'h0) begin
      errors++; $display("FAIL contention: got bus=%h cf=%b cnt=%h expected 00ff 1 0000",
                         if_m.bus, if_m.conflict, if_m.conflict_cnt);
    end
    release_all();
    step();
    checks++;
    if (if_m.bus !== 16'h00FF || if_m.conflict !== 1'b0 || if_m.conflict_cnt !== 16'h1) begin
      errors++; $display("FAIL contention_cnt: got bus=%h cf=%b cnt=%h expected 00ff 0 0001",
                         if_m.bus, if_m.conflict, if_m.conflict_cnt);
    end
  endtask

  task automatic test_pullup_wand();
    release_all();
    s_o[3][2:0] = 3'b001; s_d[3][2:0] = 3'b010;
    step();
    checks++;
    if (if_p.bus !== 1'b1) begin
      errors++; $display("FAIL pullup_idle: got %b expected 1", if_p.bus);
    end
    checks++;
    if (if_w.bus !== 1'b0 || if_w.conflict !== 1'b0) begin
      errors++; $display("FAIL wand_drive: got bus=%b cf=%b expected 0 0", if_w.bus, if_w.conflict);
    end
    release_all();
    s_o[2][3:0] = 4'b0000; s_d[2][3:0] = 4'b1101;
    step();
    checks++;
    if (if_p.bus !== 1'b0) begin
      errors++; $display("FAIL pullup_drive0: got %b expected 0", if_p.bus);
    end
    checks++;
    if (if_w.bus !== 1'b1) begin
      errors++; $display("FAIL wand_release: got %b expected 1", if_w.bus);
    end
    release_all();
    step();
    checks++;
    if (if_p.bus !== 1'b1) begin
      errors++; $display("FAIL pullup_release: got %b expected 1", if_p.bus);
    end
  endtask

  task automatic test_decay();
    logic [15:0] exp_seq [5] = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h0000, 16'h0000};
    release_all();
    s_o[1][15:0] = 16'hA5A5; s_d[1][15:0] = 16'h0;
    step();
    release_all();
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (if_d.bus !== exp_seq[c]) begin
        errors++; $display("FAIL decay_idle%0d: got %h expected %h", c + 1, if_d.bus, exp_seq[c]);
      end
    end
    s_o[1][15:0] = 16'h3C3C; s_d[1][15:0] = 16'h0;
    step();
    release_all(); step(); step();
    s_o[1][15:0] = 16'h1111; s_d[1][15:0] = 16'h0;
    step();
    release_all();
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (if_d.bus !== ((c < 3) ? 16'h1111 : 16'h0000)) begin
        errors++; $display("FAIL decay_abort%0d: got %h expected %h", c + 1, if_d.bus,
                           (c < 3) ? 16'h1111 : 16'h0000);
      end
    end
  endtask

  task automatic test_random();
    logic en [8];
    int r, kk;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        r  = $urandom_range(0, 5);
        kk = $urandom_range(0, P_N[i] - 1);
        for (int k = 0; k < 8; k++) en[k] = ($urandom_range(0, 1) == 1);
        s_o[i] = '0; s_d[i] = '1; s_clr[i] = ($urandom_range(0, 15) == 0);
        for (int k = 0; k < P_N[i]; k++)
          for (int b = 0; b < P_W[i]; b++) begin
            s_o[i][k*P_W[i] + b] = ($urandom_range(0, 1) == 1);
            case (r)
              1:       s_d[i][k*P_W[i] + b] = (k != kk);
              2:       s_d[i][k*P_W[i] + b] = ($urandom_range(0, 2) != 0);
              3:       s_d[i][k*P_W[i] + b] = !en[k];
              default: s_d[i][k*P_W[i] + b] = 1'b1;
            endcase
          end
      end
      step();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_bus(i) !== m_bus[i] || rd_flags(i) !== {m_float[i], m_conf[i], m_cnt[i]}) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: got bus=%h flags=%h expected bus=%h flags=%h",
                   i, cyc, rd_bus(i), rd_flags(i), m_bus[i], {m_float[i], m_conf[i], m_cnt[i]});
        end
      end
    end
  endtask

  task automatic test_counter();
    release_all();
    s_o[0][15:0]  = 16'hFFFF; s_d[0][15:0]  = 16'h0;
    s_o[0][31:16] = 16'h0000; s_d[0][31:16] = 16'h0;
    for (int c = 0; c < 70000; c++) step();
    checks++;
    if (if_m.conflict_cnt !== 16'hFFFF || if_m.conflict !== 1'b1) begin
      errors++; $display("FAIL cnt_saturate: got cnt=%h cf=%b expected ffff 1", if_m.conflict_cnt, if_m.conflict);
    end
    s_clr[0] = 1'b1;
    step();
    checks++;
    if (if_m.conflict_cnt !== 16'h0) begin
      errors++; $display("FAIL cnt_clear_wins: got %h expected 0000", if_m.conflict_cnt);
    end
    s_clr[0] = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (if_m.conflict_cnt !== 16'h5) begin
      errors++; $display("FAIL cnt_recount: got %h expected 0005", if_m.conflict_cnt);
    end
    rst = 1'b1; s_clr[0] = 1'b1;
    step();
    checks++;
    if (if_m.bus !== 16'hFFFF || if_m.floating !== 1'b1 || if_m.conflict !== 1'b0 ||
        if_m.conflict_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_midcount: got bus=%h fl=%b cf=%b cnt=%h expected ffff 1 0 0000",
                         if_m.bus, if_m.floating, if_m.conflict, if_m.conflict_cnt);
    end
    rst = 1'b0;
  endtask

  initial begin
    release_all();
    drive();
    test_reset();
    test_merge();
    test_contention();
    test_pullup_wand();
    test_decay();
    test_random();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_bus_resolver.md
# md_bus_resolver

Parametrised, registered resolver for one shared board-level bus in the Mega Drive top level. It replaces the hand-written per-bus merge expressions for VD, VA, ZD, ZA and the strobe lines (AS, UDS, LDS, RW, ZRD, ZWR, MREQ). It takes N drivers, each a value plus a per-bit release vector, and produces the resolved bus one MCLK after the drivers. Beyond plain merging, it adds a selectable resolution mode, a bus keeper with open-bus decay, and contention detection with a saturating event counter for debug.

## Interface
- WIDTH, 16: bus width in bits (1..32).
- DRIVERS, 4: number of drivers (1..8).
- MODE, 0: 0 = MERGE (OR of driven bits, keeper on undriven bits); 1 = PULLUP (OR of driven bits, undriven bits read 1); 2 = WIRED_AND (open-drain: bit is 0 if any driver drives 0, else 1).
- RESET_VAL, all ones: value of `bus` after reset.
- DECAY, 0: MERGE only. Number of consecutive fully-undriven cycles before `bus` is forced to FLOAT_VAL. 0 disables decay.
- FLOAT_VAL, 0: decayed open-bus value.
- MCLK  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- drv_o  in  DRIVERS*WIDTH  driver values; driver k occupies bits [k*WIDTH +: WIDTH].
- drv_d  in  DRIVERS*WIDTH  per-bit release; 1 = bit not driven, same packing as drv_o.
- cnt_clear  in  1  synchronous clear of `conflict_cnt`.
- bus  out  WIDTH  resolved bus, registered.
- floating  out  1  registered; 1 when no bit of any driver was driven in the sampled cycle.
- conflict  out  1  registered contention flag for the sampled cycle.
- conflict_cnt  out  16  saturating count of cycles with `conflict`=1.

## Operation
- Per bit b, let the driven set be the drivers k with drv_d[k][b] = 0.
- MERGE: if the driven set is non-empty, the next value is the OR of drv_o over the driven set. Otherwise the bit holds its current `bus` value.
- PULLUP: same as MERGE, except an empty driven set gives 1.
- WIRED_AND: the next value is 0 if any driven driver has drv_o = 0, else 1. drv_o of released drivers is ignored.
- Contention, MODE 0/1 only: a bit has two or more drivers in the driven set whose drv_o values differ. `conflict` is the OR of this over all bits. In MODE 2, `conflict` is always 0.
- Decay, MODE 0 with DECAY > 0:
  - An idle counter increments on every cycle with all bits undriven and clears on any driven cycle.
  - On the cycle the counter reaches DECAY, `bus` is loaded with FLOAT_VAL.
  - The counter then saturates at DECAY and `bus` stays at FLOAT_VAL until a driver drives.
  - Counter width is clog2(DECAY+1).
- conflict_cnt:
  - Increments when a registered conflict is produced.
  - Saturates at 16'hFFFF.
  - cnt_clear wins over a simultaneous increment; the result is 0.

## Timing
- Latency is exactly one MCLK cycle: drivers sampled at edge n appear on `bus`/`floating`/`conflict` after edge n. `conflict_cnt` reflects that conflict one cycle later.
- No combinational path from any input to any output.
- Reset values: `bus` = RESET_VAL, `floating` = 1, `conflict` = 0, `conflict_cnt` = 0, idle counter = 0.
- Reset has priority over all other inputs, including cnt_clear.
- The first non-reset cycle resolves normally. A fully undriven first cycle in MERGE holds RESET_VAL.
- Decay timing: with DECAY = D, the release begins at edge n and `bus` = FLOAT_VAL after edge n+D-1. A driven sample at any edge aborts the decay with no residual count.
- A partially driven cycle counts as driven for decay. Its undriven bits keep their held value.

## Structure
- Shared package `md_bus_pkg` holds:
  - mode constants BUS_MERGE = 0, BUS_PULLUP = 1, BUS_WIRED_AND = 2;
  - the conflict counter width constant (16).
- One sub-module, `md_bus_decay`: the idle counter plus compare, parameter DECAY, outputs a `decay_now` strobe.
- Per-bit resolution and contention logic are generate loops in the top module.
- Out-of-range parameter values are caught by elaboration-time checks.

## Test plan
- MERGE, W=16, N=4, RESET_VAL=16'hFFFF:
  - hold reset: bus=FFFF, floating=1;
  - driver0 drives 16'h1234 with others released: bus=1234 next cycle;
  - release all: bus holds 1234, floating=1.
- MERGE contention: driver0 = 16'h00F0 and driver2 = 16'h000F, both fully driven -> bus=00FF, conflict=1 for one cycle, conflict_cnt=1 a cycle later.
- PULLUP, W=1: no driver -> bus=1; driver1 drives 0 -> bus=0 next cycle.
- WIRED_AND, W=1, N=3: driver0 drives 1 and driver2 drives 0 -> bus=0, conflict=0; all released -> bus=1.
- Decay, MERGE with DECAY=4, FLOAT_VAL=0:
  - drive 16'hA5A5 then release: bus=A5A5 for 3 cycles, then 0000;
  - a second scenario re-drives on the 3rd idle cycle: no decay occurs.
- Counter: force contention for 70000 cycles -> conflict_cnt=FFFF. Then assert cnt_clear together with a conflict -> 0. Then assert reset mid-count -> all outputs return to their reset values.
